// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: FSM states and fetch-stage mode codes.
// Fetch decodes mode with the same constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    // A frame may not ask for more words than the memory holds.
    function automatic logic len_too_big(
        input logic [15:0] n,
        input int unsigned aw
    );
        return {16'd0, n} > (32'd1 << aw);
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte packer: four accepted bytes form one 32-bit word.
// word is the word as it would stand after taking the current byte.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  rx_byte,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  cnt;
    logic [23:0] sr;

    assign word      = {rx_byte, sr};
    assign word_full = take & (cnt == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 2'd0;
            sr  <= 24'd0;
        end else if (clear) begin
            cnt <= 2'd0;
            sr  <= 24'd0;
        end else if (take) begin
            cnt <= cnt + 2'd1;
            sr  <= word[31:8];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: byte stream -> word writes into the fetch stage.
// Holds the core in reset while loading, releases it with mode=RUN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_req,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    output logic [1:0]      mode,
    output logic [31:0]     w_addr,
    output logic [31:0]     in_data,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [ADDR_W:0] words_loaded
);

    state_t              state;
    logic                len_phase;
    logic [7:0]          len_lo;
    logic [15:0]         len;
    logic [ADDR_W-1:0]   addr;

    logic                xfer;
    logic                take;
    logic                start;
    logic                last;
    logic                word_full;
    logic [31:0]         word;
    logic [15:0]         n_rx;

    assign xfer  = rx_valid & rx_ready;
    assign take  = xfer & (state == S_DATA);
    assign start = load_req &
                   (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign n_rx  = {rx_data, len_lo};
    assign last  = ({{(31 - ADDR_W){1'b0}}, words_loaded} + 32'd1)
                   == {16'd0, len};

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start | (state == S_WRITE)),
        .take      (take),
        .rx_byte   (rx_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            len_phase    <= 1'b0;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            addr         <= '0;
            rx_ready     <= 1'b0;
            mode         <= MODE_HOLD;
            w_addr       <= 32'd0;
            in_data      <= 32'd0;
            core_rst     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_LEN;
                        len_phase    <= 1'b0;
                        rx_ready     <= 1'b1;
                        mode         <= MODE_HOLD;
                        core_rst     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                S_LEN: begin
                    if (xfer && !len_phase) begin
                        len_lo    <= rx_data;
                        len_phase <= 1'b1;
                    end else if (xfer) begin
                        len <= n_rx;
                        if (n_rx == 16'd0) begin
                            state    <= S_DONE;
                            rx_ready <= 1'b0;
                            mode     <= MODE_RUN;
                            core_rst <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (len_too_big(n_rx, ADDR_W)) begin
                            state    <= S_ERR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= S_DATA;
                            addr  <= ADDR_W'(BASE_ADDR);
                        end
                    end
                end
                S_DATA: begin
                    if (word_full) begin
                        state    <= S_WRITE;
                        rx_ready <= 1'b0;
                        mode     <= MODE_WRITE;
                        w_addr   <= {{(32 - ADDR_W){1'b0}}, addr};
                        in_data  <= word;
                    end
                end
                S_WRITE: begin
                    // Single write cycle; address wraps naturally at depth.
                    mode         <= MODE_HOLD;
                    addr         <= addr + 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                    if (last) begin
                        state    <= S_DONE;
                        mode     <= MODE_RUN;
                        core_rst <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state    <= S_DATA;
                        rx_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames, a fetch-memory model fed by
// an expected-write queue, and literal checks on final status.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_req = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [1:0]  mode;
    logic [31:0] w_addr;
    logic [31:0] in_data;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] words_loaded;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_a [$];
    logic [31:0] exp_d [$];
    logic [31:0] prog [0:1];
    logic [1:0]  prev_mode = 2'b11;

    imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_req     (load_req),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mode         (mode),
        .w_addr       (w_addr),
        .in_data      (in_data),
        .core_rst     (core_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Fetch-side model: every mode=10 cycle must match the next expected write.
    always @(negedge clk) begin
        if (rst) begin
            chk("mode_legal", 32'(mode != 2'b01), 32'd1);
            if (mode == 2'b10) begin
                chk("single_write", 32'(prev_mode == 2'b10), 32'd0);
                chk("write_hold", {30'd0, rx_ready, core_rst}, 32'd1);
                if (exp_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %h data %h",
                             w_addr, in_data);
                end else begin
                    chk("write_addr", w_addr, exp_a.pop_front());
                    chk("write_data", in_data, exp_d.pop_front());
                end
                mem[w_addr[9:0]] = in_data;
            end
        end
        prev_mode = mode;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        rx_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        rdy = 1'b0;
        do begin
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        rx_valid = 1'b0;
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL byte_timeout: got ready 0 want 1");
        end
    endtask

    task automatic send_prog(input int n, input bit gaps);
        send_byte(8'(n), 0);
        send_byte(8'(n >> 8), 0);
        for (int w = 0; w < n; w++) begin
            exp_a.push_back(32'(w % 1024));
            exp_d.push_back(prog[w]);
            for (int k = 0; k < 4; k++)
                send_byte(8'(prog[w] >> (8 * k)),
                          gaps ? int'($urandom_range(0, 1)) : 0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mode"}, 32'(mode), 32'd3);
        chk({tag, "_waddr"}, w_addr, 32'd0);
        chk({tag, "_data"}, in_data, 32'd0);
        chk({tag, "_flags"},
            {27'd0, core_rst, rx_ready, busy, done, err}, 32'h10);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic chk_done2(input string tag);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
        chk({tag, "_flags"},
            {27'd0, core_rst, rx_ready, busy, done, err}, 32'h02);
        chk({tag, "_words"}, 32'(words_loaded), 32'd2);
        chk({tag, "_drain"}, 32'(exp_a.size()), 32'd0);
        chk({tag, "_mem0"}, mem[0], 32'h0000_0013);
        chk({tag, "_mem1"}, mem[1], 32'h0010_0093);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        prog[0] = 32'h0000_0013;
        prog[1] = 32'h0010_0093;
        mem[0]  = 32'hdead_beef;
        mem[1]  = 32'hdead_beef;

        // 1: reset, then idle ignores the stream
        tick();
        chk_reset_vals("rst");
        #6 rst = 1'b1;
        tick();
        chk_reset_vals("idle");
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_ready", {30'd0, rx_ready, mode == 2'b11}, 32'd1);
        end
        rx_valid = 1'b0;

        // 2: two-word program, latency of the first write
        pulse_load();
        chk("start_flags", {29'd0, busy, rx_ready, core_rst}, 32'd7);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        exp_a.push_back(32'd0);
        exp_d.push_back(32'h0000_0013);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("lat_write", {29'd0, mode, rx_ready}, 32'b100);
        exp_a.push_back(32'd1);
        exp_d.push_back(32'h0010_0093);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        wait_idle();
        chk_done2("t2");

        // 3: empty frame from DONE
        pulse_load();
        chk("relaunch", {29'd0, mode, done}, 32'b110);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_idle();
        chk("n0_flags", {29'd0, done, err, core_rst}, 32'b100);
        chk("n0_words", 32'(words_loaded), 32'd0);
        chk("n0_mode", 32'(mode), 32'd0);

        // 4: one word too many, then recover
        pulse_load();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        wait_idle();
        chk("err_flags",
            {27'd0, core_rst, rx_ready, busy, done, err}, 32'h11);
        chk("err_mode", 32'(mode), 32'd3);
        pulse_load();
        chk("err_clear", {30'd0, err, busy}, 32'd1);
        mem[0] = 32'hdead_beef;
        send_prog(1, 1'b0);
        wait_idle();
        chk("rec_done", {30'd0, done, err}, 32'b10);
        chk("rec_mem0", mem[0], 32'h0000_0013);
        chk("rec_words", 32'(words_loaded), 32'd1);

        // 5: gappy stream plus an ignored mid-load request
        mem[0] = 32'hdead_beef;
        mem[1] = 32'hdead_beef;
        pulse_load();
        send_byte(8'h02, 1);
        send_byte(8'h00, 0);
        pulse_load();
        chk("busy_ignore", {30'd0, busy, rx_ready}, 32'd3);
        exp_a.push_back(32'd0);
        exp_d.push_back(32'h0000_0013);
        exp_a.push_back(32'd1);
        exp_d.push_back(32'h0010_0093);
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 4; k++)
                send_byte(8'(prog[w] >> (8 * k)), 1 - (k % 2));
        wait_idle();
        chk_done2("t5");

        // 6: reset in the middle of a word
        pulse_load();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        tick();
        rst = 1'b1;
        tick();
        mem[0] = 32'hdead_beef;
        mem[1] = 32'hdead_beef;
        pulse_load();
        send_prog(2, 1'b1);
        wait_idle();
        chk_done2("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
